shreg4_piso_siso: RTL and testbench

4-bit shift-register block with three independent channels sharing one clock and reset: a parallel-load/shift-right register (SHReg4 channel), a parallel-in/serial-out converter (PISO channel) and a serial-in/serial-out delay line (SISO channel). It is the serial/parallel conversion leaf used by link-level logic. Each channel has its own control inputs and never affects the others.

---
 rtl/shreg4_pkg.sv | 12 +
 rtl/shreg_core.sv | 38 +++
 rtl/shreg4_piso_siso.sv | 129 ++++++++++++
 tb/tb_shreg4_piso_siso.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/shreg4_pkg.sv
// Shared constants and types for the shreg4_piso_siso block.
package shreg4_pkg;

    localparam int unsigned WIDTH = 4;

    typedef logic [$clog2(WIDTH+1)-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = cnt_t'(WIDTH);
    localparam cnt_t CNT_LAST = cnt_t'(WIDTH - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

endpackage

// File: rtl/shreg_core.sv
// WIDTH-bit register: synchronous reset, parallel load, shift right with serial in, hold.
module shreg_core
    import shreg4_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [Width-1:0] din,
    input  logic             sin,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_d, q_q;

    // Load wins over shift; neither means hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (shift) begin
            q_d = {sin, q_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shreg4_piso_siso.sv
// Three independent 4-bit shift channels: SHReg4 load/shift, PISO and SISO.
// Define SHREG4_DONE_EN to build the done flags and their bit counters.
module shreg4_piso_siso
    import shreg4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             shr,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    input  logic             pl,
    input  logic             piso_en,
    output logic             piso_out,
    output logic             piso_done,
    input  logic             sl,
    input  logic             siso_en,
    input  logic             siso_in,
    output logic             siso_out,
    output logic             siso_done
);

    logic [WIDTH-1:0] shr_q, piso_q, siso_q;
    logic             piso_shift, siso_shift;
    logic             piso_out_q;

    // SHReg4 channel: always either loads or shifts, serial in is pin MSB.
    shreg_core #(
        .Width (WIDTH)
    ) u_shr (
        .clk   (clk),
        .rst   (rst),
        .load  (~shr),
        .shift (shr),
        .din   (pin),
        .sin   (pin[WIDTH-1]),
        .q     (shr_q)
    );

    assign pout = shr_q;
    assign sout = shr_q[0];

    shreg_core #(
        .Width (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (pl),
        .shift (piso_shift),
        .din   (pin),
        .sin   (1'b0),
        .q     (piso_q)
    );

    shreg_core #(
        .Width (WIDTH)
    ) u_siso (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b0),
        .shift (siso_shift),
        .din   ('0),
        .sin   (siso_in),
        .q     (siso_q)
    );

    assign siso_shift = sl & siso_en;
    assign siso_out   = siso_q[0];

`ifdef SHREG4_DONE_EN
    cnt_t piso_cnt_q, siso_cnt_q;
    logic piso_done_q, siso_done_q;

    // Enables past the WIDTH-th bit are ignored until the next load.
    assign piso_shift = ~pl & piso_en & (piso_cnt_q < CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            piso_cnt_q  <= '0;
            piso_done_q <= 1'b0;
        end else if (pl) begin
            piso_cnt_q  <= '0;
            piso_done_q <= 1'b0;
        end else if (piso_shift) begin
            piso_cnt_q <= piso_cnt_q + CNT_ONE;
            if (piso_cnt_q == CNT_LAST) begin
                piso_done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            siso_cnt_q  <= '0;
            siso_done_q <= 1'b0;
        end else if (!sl) begin
            siso_cnt_q  <= '0;
            siso_done_q <= 1'b0;
        end else if (siso_shift && (siso_cnt_q < CNT_MAX)) begin
            siso_cnt_q <= siso_cnt_q + CNT_ONE;
            if (siso_cnt_q == CNT_LAST) begin
                siso_done_q <= 1'b1;
            end
        end
    end

    assign piso_done = piso_done_q;
    assign siso_done = siso_done_q;
`else
    assign piso_shift = ~pl & piso_en;
    assign piso_done  = 1'b0;
    assign siso_done  = 1'b0;
`endif

    // piso_out keeps the last emitted bit across loads and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            piso_out_q <= 1'b0;
        end else if (piso_shift) begin
            piso_out_q <= piso_q[0];
        end
    end

    assign piso_out = piso_out_q;

    logic unused_bits;
    assign unused_bits = ^{piso_q[WIDTH-1:1], siso_q[WIDTH-1:1]};

endmodule

// File: tb/tb_shreg4_piso_siso.sv
// Directed self-checking bench for shreg4_piso_siso (default or SHREG4_DONE_EN build).
module tb_shreg4_piso_siso;

`ifdef SHREG4_DONE_EN
    localparam logic DONE = 1'b1;
`else
    localparam logic DONE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, shr, pl, piso_en, sl, siso_en, siso_in;
    logic [3:0] pin, pout;
    logic       sout, piso_out, piso_done, siso_out, siso_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shreg4_piso_siso dut (
        .clk       (clk),
        .rst       (rst),
        .pin       (pin),
        .shr       (shr),
        .pout      (pout),
        .sout      (sout),
        .pl        (pl),
        .piso_en   (piso_en),
        .piso_out  (piso_out),
        .piso_done (piso_done),
        .sl        (sl),
        .siso_en   (siso_en),
        .siso_in   (siso_in),
        .siso_out  (siso_out),
        .siso_done (siso_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic pend;
        rst = 1'b1; shr = 1'b0; pl = 1'b0; piso_en = 1'b0;
        sl = 1'b0; siso_en = 1'b0; siso_in = 1'b0; pin = 4'b0000;
        step();
        step();
        check("rst_pout", pout, 4'b0000);
        check("rst_sout", {3'b0, sout}, 4'd0);
        check("rst_piso_out", {3'b0, piso_out}, 4'd0);
        check("rst_piso_done", {3'b0, piso_done}, 4'd0);
        check("rst_siso_out", {3'b0, siso_out}, 4'd0);
        check("rst_siso_done", {3'b0, siso_done}, 4'd0);

        // SHReg4 load then shift right with pin[3]=0
        rst = 1'b0; shr = 1'b0; pin = 4'b1011;
        step();
        check("shr_load", pout, 4'b1011);
        check("shr_load_sout", {3'b0, sout}, 4'd1);
        shr = 1'b1; pin = 4'b0011;
        step(); check("shr_s1", pout, 4'b0101); check("shr_s1_sout", {3'b0, sout}, 4'd1);
        step(); check("shr_s2", pout, 4'b0010); check("shr_s2_sout", {3'b0, sout}, 4'd0);
        step(); check("shr_s3", pout, 4'b0001); check("shr_s3_sout", {3'b0, sout}, 4'd1);
        step(); check("shr_s4", pout, 4'b0000); check("shr_s4_sout", {3'b0, sout}, 4'd0);
        pin = 4'b1000;
        step(); check("shr_msb_in", pout, 4'b1000);
        check("piso_idle_out", {3'b0, piso_out}, 4'd0);

        // PISO 1011 out LSB first, with a 2-cycle stall mid-stream
        shr = 1'b0; pin = 4'b1011; pl = 1'b1;
        step();
        check("piso_load_done", {3'b0, piso_done}, 4'd0);
        pl = 1'b0; piso_en = 1'b1;
        step(); check("piso_b0", {3'b0, piso_out}, 4'd1); check("piso_b0_done", {3'b0, piso_done}, 4'd0);
        step(); check("piso_b1", {3'b0, piso_out}, 4'd1);
        piso_en = 1'b0;
        step(); check("piso_stall1", {3'b0, piso_out}, 4'd1);
        step(); check("piso_stall2", {3'b0, piso_out}, 4'd1);
        check("piso_stall_done", {3'b0, piso_done}, 4'd0);
        piso_en = 1'b1;
        step(); check("piso_b2", {3'b0, piso_out}, 4'd0); check("piso_b2_done", {3'b0, piso_done}, 4'd0);
        step(); check("piso_b3", {3'b0, piso_out}, 4'd1);
        check("piso_b3_done", {3'b0, piso_done}, {3'b0, DONE});
        // Past the 4th bit: held 1 with done, zeros without
        pend = DONE;
        step(); check("piso_after1", {3'b0, piso_out}, {3'b0, pend});
        check("piso_after1_done", {3'b0, piso_done}, {3'b0, DONE});
        step(); check("piso_after2", {3'b0, piso_out}, {3'b0, pend});

        // Reload mid-flight clears done, then 0110 streams out 0,1,...
        pin = 4'b0110; pl = 1'b1;
        step(); check("piso_reload_done", {3'b0, piso_done}, 4'd0);
        check("piso_reload_out", {3'b0, piso_out}, {3'b0, pend});
        pl = 1'b0;
        step(); check("piso_r0", {3'b0, piso_out}, 4'd0);
        step(); check("piso_r1", {3'b0, piso_out}, 4'd1);

        // SISO mid-transfer plus PISO mid-stream, then reset
        sl = 1'b1; siso_en = 1'b1; siso_in = 1'b1;
        step(); check("siso_pre_rst", {3'b0, siso_out}, 4'd0);
        check("piso_r2", {3'b0, piso_out}, 4'd1);
        rst = 1'b1; shr = 1'b1; pin = 4'b1111; pl = 1'b0;
        step();
        check("mid_rst_pout", pout, 4'b0000);
        check("mid_rst_piso_out", {3'b0, piso_out}, 4'd0);
        check("mid_rst_piso_done", {3'b0, piso_done}, 4'd0);
        check("mid_rst_siso_out", {3'b0, siso_out}, 4'd0);
        check("mid_rst_siso_done", {3'b0, siso_done}, 4'd0);

        // SISO from power-up: shift in 1,1,0,1 -> reg 1011
        rst = 1'b0; shr = 1'b0; pin = 4'b0000; piso_en = 1'b0;
        siso_in = 1'b1;
        step(); check("siso_1", {3'b0, siso_out}, 4'd0); check("siso_1_done", {3'b0, siso_done}, 4'd0);
        step(); check("siso_2", {3'b0, siso_out}, 4'd0);
        siso_in = 1'b0;
        step(); check("siso_3", {3'b0, siso_out}, 4'd0); check("siso_3_done", {3'b0, siso_done}, 4'd0);
        siso_in = 1'b1;
        step(); check("siso_4", {3'b0, siso_out}, 4'd1);
        check("siso_4_done", {3'b0, siso_done}, {3'b0, DONE});
        siso_en = 1'b0; siso_in = 1'b0;
        step(); check("siso_hold", {3'b0, siso_out}, 4'd1);
        check("siso_hold_done", {3'b0, siso_done}, {3'b0, DONE});
        sl = 1'b0; siso_en = 1'b1;
        step(); check("siso_sl0_out", {3'b0, siso_out}, 4'd1);
        check("siso_sl0_done", {3'b0, siso_done}, 4'd0);
        // Remaining bits 1,0,1 of 1011 come out on the next shifts
        sl = 1'b1;
        step(); check("siso_drain1", {3'b0, siso_out}, 4'd1);
        step(); check("siso_drain2", {3'b0, siso_out}, 4'd0);
        step(); check("siso_drain3", {3'b0, siso_out}, 4'd1);
        check("siso_drain3_done", {3'b0, siso_done}, 4'd0);
        check("pout_after", pout, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
